pipeline_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage RISC-V pipeline. Shadows the dest-register state of EX, MEM, WB.
//  Per cycle it drives PC/IF_ID write-enables, bubble insertion into ID_EX, squash of IF_ID/ID_EX on taken

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register width, forwarding selects and the
// per-stage destination-register slot tracked by the hazard controller.
package rv_pipe_pkg;

  localparam int REG_AW      = 5;
  localparam int FLUSH_DEPTH = 2;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } slot_t;

  localparam slot_t SLOT_INVALID = '{
    vld:      1'b0,
    rd:       {REG_AW{1'b0}},
    regwrite: 1'b0,
    memread:  1'b0
  };

  // A slot produces a forwardable/stallable result only when it really writes a non-x0 register.
  function automatic logic writes_reg(input slot_t s);
    return s.vld & s.regwrite & (s.rd != {REG_AW{1'b0}});
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_ctrl_if;
  import rv_pipe_pkg::*;

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_branch_taken;

  logic              pc_write;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_bubble;
  fwd_sel_e          fwd_a;
  fwd_sel_e          fwd_b;
  logic [15:0]       stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_regwrite, id_memread, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b, stall_cnt
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one EX source operand; the youngest producer (MEM) wins over WB.
module fwd_unit
  import rv_pipe_pkg::*;
(
  input  slot_t             i_mem_slot,
  input  slot_t             i_wb_slot,
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic              i_ex_use,
  output fwd_sel_e          o_fwd
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = writes_reg(i_mem_slot) & i_ex_use & (i_mem_slot.rd == i_ex_rs);
  assign w_wb_hit  = writes_reg(i_wb_slot)  & i_ex_use & (i_wb_slot.rd  == i_ex_rs);

  // Priority select between EX_MEM result, MEM_WB writeback data and the register file.
  always_comb begin
    o_fwd = FWD_REG;
    if (w_mem_hit) begin
      o_fwd = FWD_EXMEM;
    end else if (w_wb_hit) begin
      o_fwd = FWD_MEMWB;
    end else begin
      o_fwd = FWD_REG;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: load-use stall, branch squash,
// operand forwarding selects and a saturating load-use stall counter.
module pipeline_hazard_ctrl
  import rv_pipe_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz_if
);

  slot_t             r_ex_slot;
  slot_t             r_mem_slot;
  slot_t             r_wb_slot;
  logic [REG_AW-1:0] r_ex_rs1;
  logic [REG_AW-1:0] r_ex_rs2;
  logic              r_ex_use1;
  logic              r_ex_use2;
  logic [15:0]       r_stall_cnt;

  slot_t             w_id_slot;
  logic              w_flush;
  logic              w_rs1_dep;
  logic              w_rs2_dep;
  logic              w_load_use;
  logic              w_stall;
  logic              w_bubble;

  assign w_flush    = hz_if.ex_branch_taken;
  assign w_rs1_dep  = hz_if.id_use_rs1 & (hz_if.id_rs1 == r_ex_slot.rd);
  assign w_rs2_dep  = hz_if.id_use_rs2 & (hz_if.id_rs2 == r_ex_slot.rd);
  assign w_load_use = hz_if.id_valid & writes_reg(r_ex_slot) & r_ex_slot.memread
                    & (w_rs1_dep | w_rs2_dep);
  // A taken branch squashes the dependent instruction, so the stall is dropped.
  assign w_stall    = w_load_use & ~w_flush;
  assign w_bubble   = w_stall | w_flush;

  assign w_id_slot = '{
    vld:      hz_if.id_valid,
    rd:       hz_if.id_rd,
    regwrite: hz_if.id_regwrite,
    memread:  hz_if.id_memread
  };

  assign hz_if.pc_write     = ~w_stall;
  assign hz_if.if_id_write  = ~w_stall;
  assign hz_if.if_id_flush  = w_flush & rst_n;
  assign hz_if.id_ex_bubble = w_bubble & rst_n;
  assign hz_if.stall_cnt    = r_stall_cnt;

  // Shift the EX/MEM/WB destination slots alongside the pipeline registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_slot  <= SLOT_INVALID;
      r_mem_slot <= SLOT_INVALID;
      r_wb_slot  <= SLOT_INVALID;
      r_ex_rs1   <= {REG_AW{1'b0}};
      r_ex_rs2   <= {REG_AW{1'b0}};
      r_ex_use1  <= 1'b0;
      r_ex_use2  <= 1'b0;
    end else begin
      r_wb_slot  <= r_mem_slot;
      r_mem_slot <= r_ex_slot;
      if (w_bubble) begin
        r_ex_slot <= SLOT_INVALID;
        r_ex_rs1  <= {REG_AW{1'b0}};
        r_ex_rs2  <= {REG_AW{1'b0}};
        r_ex_use1 <= 1'b0;
        r_ex_use2 <= 1'b0;
      end else begin
        r_ex_slot <= w_id_slot;
        r_ex_rs1  <= hz_if.id_rs1;
        r_ex_rs2  <= hz_if.id_rs2;
        r_ex_use1 <= hz_if.id_use_rs1 & hz_if.id_valid;
        r_ex_use2 <= hz_if.id_use_rs2 & hz_if.id_valid;
      end
    end
  end

  // Saturating count of load-use stall cycles.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'h0001;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  fwd_unit u_fwd_a (
    .i_mem_slot (r_mem_slot),
    .i_wb_slot  (r_wb_slot),
    .i_ex_rs    (r_ex_rs1),
    .i_ex_use   (r_ex_use1),
    .o_fwd      (hz_if.fwd_a)
  );

  fwd_unit u_fwd_b (
    .i_mem_slot (r_mem_slot),
    .i_wb_slot  (r_wb_slot),
    .i_ex_rs    (r_ex_rs2),
    .i_ex_use   (r_ex_use2),
    .o_fwd      (hz_if.fwd_b)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// instruction streams, checked against an instruction-history reference model.
module tb_pipeline_hazard_ctrl;
  import rv_pipe_pkg::*;

  typedef struct {
    bit vld; int rd; bit rw; bit mr;
    int rs1; bit u1; int rs2; bit u2;
  } instr_t;

  typedef struct {
    bit pc_write; bit if_id_write; bit if_id_flush; bit id_ex_bubble;
    int fwd_a; int fwd_b; int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz();
  pipeline_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .hz_if(hz));

  exp_t   exp_q[$];
  instr_t pipe_q[$];   // index 0 = EX, 1 = MEM, 2 = WB (oldest)
  int     model_cnt;
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     last_stall;
  instr_t last_id;

  function automatic instr_t mk(bit vld, int rd, bit rw, bit mr, int rs1, bit u1, int rs2, bit u2);
    instr_t t;
    t.vld = vld; t.rd = rd; t.rw = rw; t.mr = mr;
    t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
    return t;
  endfunction

  function automatic instr_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void model_reset();
    pipe_q.delete();
    repeat (3) pipe_q.push_back(nop());
    model_cnt = 0;
  endfunction

  // Nearest older writer of rs among instructions in MEM (age 1) or WB (age 2).
  function automatic int model_fwd(int rs, bit used);
    if (!used || rs == 0) return 0;
    for (int age = 1; age <= 2; age++)
      if (pipe_q[age].vld && pipe_q[age].rw && pipe_q[age].rd == rs)
        return (age == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  task automatic step(input instr_t id, input bit br, input bit rst_low);
    exp_t   e;
    instr_t ex;
    instr_t entering;
    bit     hazard;
    bit     stall;
    @(posedge clk);
    hz.id_valid        = id.vld;
    hz.id_rd           = REG_AW'(id.rd);
    hz.id_regwrite     = id.rw;
    hz.id_memread      = id.mr;
    hz.id_rs1          = REG_AW'(id.rs1);
    hz.id_use_rs1      = id.u1;
    hz.id_rs2          = REG_AW'(id.rs2);
    hz.id_use_rs2      = id.u2;
    hz.ex_branch_taken = br;
    rst_n              = !rst_low;
    stall = 0;
    if (rst_low) begin
      e = '{1, 1, 0, 0, 0, 0, 0};
      model_reset();
    end else begin
      ex = pipe_q[0];
      hazard = id.vld && ex.vld && ex.mr && ex.rw && ex.rd != 0 &&
               ((id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd));
      stall = hazard && !br;
      e.pc_write     = !stall;
      e.if_id_write  = !stall;
      e.if_id_flush  = br;
      e.id_ex_bubble = br || stall;
      e.fwd_a        = model_fwd(ex.rs1, ex.u1);
      e.fwd_b        = model_fwd(ex.rs2, ex.u2);
      e.cnt          = model_cnt;
      entering = (br || stall) ? nop() : id;
      if (!entering.vld) begin
        entering.u1 = 0;
        entering.u2 = 0;
      end
      pipe_q.push_front(entering);
      void'(pipe_q.pop_back());
      if (stall && model_cnt < 65535) model_cnt++;
    end
    exp_q.push_back(e);
    last_stall = stall;
    last_id    = id;
  endtask

  // Pull reset low in the middle of the cycle just checked, then hold it one more cycle.
  task automatic mid_cycle_reset();
    #3;
    rst_n = 1'b0;
    model_reset();
    step(nop(), 0, 1);
  endtask

  // Monitor: the DUT presents a full output vector every cycle; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ctl", {28'd0, hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_bubble},
              {28'd0, e.pc_write, e.if_id_write, e.if_id_flush, e.id_ex_bubble});
        check("fwd", {28'd0, hz.fwd_a, hz.fwd_b}, {28'd0, 2'(e.fwd_a), 2'(e.fwd_b)});
        check("stall_cnt", {16'd0, hz.stall_cnt}, 32'(e.cnt));
      end
    end
  end

  initial begin
    instr_t ld5, add_dep, add5, rnd;
    int     wait_cycles;
    model_reset();
    hz.id_valid = 0; hz.id_rd = '0; hz.id_regwrite = 0; hz.id_memread = 0;
    hz.id_rs1 = '0; hz.id_use_rs1 = 0; hz.id_rs2 = '0; hz.id_use_rs2 = 0;
    hz.ex_branch_taken = 0;

    step(nop(), 0, 1);
    step(nop(), 0, 1);

    ld5     = mk(1, 5, 1, 1, 1, 1, 0, 0);
    add_dep = mk(1, 6, 1, 0, 5, 1, 7, 1);
    add5    = mk(1, 5, 1, 0, 1, 1, 2, 1);

    // Load-use stall then WB forwarding.
    step(ld5, 0, 0); step(add_dep, 0, 0); step(add_dep, 0, 0); step(nop(), 0, 0); step(nop(), 0, 0);
    // Back-to-back ALU dependency on both operands.
    step(add5, 0, 0); step(mk(1, 8, 1, 0, 5, 1, 5, 1), 0, 0); step(nop(), 0, 0); step(nop(), 0, 0);
    // MEM beats WB; x0 operand never forwarded.
    step(add5, 0, 0); step(add5, 0, 0); step(mk(1, 9, 1, 0, 5, 1, 0, 1), 0, 0);
    step(nop(), 0, 0); step(nop(), 0, 0);
    // Taken branch while a load-use is pending.
    step(ld5, 0, 0); step(add_dep, 1, 0); step(nop(), 0, 0); step(nop(), 0, 0);
    // Load into x0 is ignored; store reading the load result as rs2 only.
    step(mk(1, 0, 1, 1, 1, 1, 0, 0), 0, 0); step(mk(1, 1, 1, 0, 0, 1, 0, 1), 0, 0); step(nop(), 0, 0);
    step(mk(1, 3, 1, 1, 1, 1, 0, 0), 0, 0); step(mk(1, 0, 0, 0, 2, 1, 3, 1), 0, 0);
    step(mk(1, 0, 0, 0, 2, 1, 3, 1), 0, 0); step(nop(), 0, 0); step(nop(), 0, 0);
    // Reset during a stall cycle and during a flush cycle.
    step(ld5, 0, 0); step(add_dep, 0, 0); mid_cycle_reset();
    step(mk(1, 4, 1, 0, 5, 1, 6, 1), 0, 0); step(nop(), 0, 0);
    step(ld5, 0, 0); step(add_dep, 1, 0); mid_cycle_reset();
    step(mk(1, 4, 1, 0, 5, 1, 6, 1), 0, 0); step(nop(), 0, 0);
    // Counter saturation.
    @(negedge clk); #1;
    force dut.r_stall_cnt = 16'hFFFF;
    #1;
    release dut.r_stall_cnt;
    model_cnt = 65535;
    step(ld5, 0, 0); step(add_dep, 0, 0); step(add_dep, 0, 0); step(nop(), 0, 0);

    // Random streams over a small register set to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        repeat ($urandom_range(1, 2)) step(nop(), $urandom_range(0, 1) == 1, 1);
      end else begin
        if (last_stall && $urandom_range(0, 3) != 0) rnd = last_id;
        else rnd = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 7), $urandom_range(0, 1) == 1);
        step(rnd, $urandom_range(0, 9) == 0, 0);
      end
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #4;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
